serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_pkg.sv | 19 +
 rtl/serial_add_ctrl_if.sv | 27 ++
 rtl/serial_bit_cell.sv | 45 ++++
 rtl/serial_add_ctrl.sv | 147 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial add/subtract controller: FSM state
// encoding, operation codes and the carry majority function.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Carry out of a full adder: true when at least two inputs are set.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Parallel operand/result bundle between an operand producer and the
// serial add/subtract controller.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             START;
    logic             OP;
    logic [WIDTH-1:0] A_IN;
    logic [WIDTH-1:0] B_IN;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] SUM_OUT;
    logic             COUT_OUT;
    logic             OVF_OUT;

    // Producer side: issues requests and consumes results.
    modport master (
        output START, OP, A_IN, B_IN,
        input  BUSY, DONE, SUM_OUT, COUT_OUT, OVF_OUT
    );

    // Controller side.
    modport slave (
        input  START, OP, A_IN, B_IN,
        output BUSY, DONE, SUM_OUT, COUT_OUT, OVF_OUT
    );
endinterface

// File: rtl/serial_bit_cell.sv
// Registered 1-bit full adder. The carry flop is loaded with CIN when LD is
// high and advances to the cell's carry out when EN is high; the sum and the
// next carry are presented combinationally from the current carry.
module serial_bit_cell
    import serial_add_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic LD,
    input  logic CIN,
    input  logic EN,
    input  logic A,
    input  logic B,
    output logic S,
    output logic CO
);

    logic carry_q;
    logic carry_d;

    assign S  = A ^ B ^ carry_q;
    assign CO = maj3(A, B, carry_q);

    // Next carry: load has priority over the shift-step update.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        carry_d = carry_q;
        if (LD) begin
            carry_d = CIN;
        end else if (EN) begin
            carry_d = CO;
        end
    end

    // Carry state register.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (RST) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor controller. Captures operands on an
// accepted START, feeds one bit per clock (LSB first) through a registered
// full-adder cell, then publishes the parallel result with carry and signed
// overflow together with a one-cycle DONE pulse.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    serial_add_ctrl_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_PREV = CNT_W'(WIDTH - 2);

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] a_sh_q,    a_sh_d;
    logic [WIDTH-1:0] b_sh_q,    b_sh_d;
    logic [WIDTH-1:0] sum_sh_q,  sum_sh_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             cmsb_q,    cmsb_d;    // carry into the MSB position
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [WIDTH-1:0] sum_out_q, sum_out_d;
    logic             cout_q,    cout_d;
    logic             ovf_q,     ovf_d;

    logic             cell_ld;
    logic             cell_en;
    logic             cell_s;
    logic             cell_co;

    // The cell sees the current LSBs; its carry is preset to OP on accept so
    // subtraction becomes A + ~B + 1.
    serial_bit_cell u_cell (
        .CLK (CLK),
        .RST (RST),
        .LD  (cell_ld),
        .CIN (bus.OP),
        .EN  (cell_en),
        .A   (a_sh_q[0]),
        .B   (b_sh_q[0]),
        .S   (cell_s),
        .CO  (cell_co)
    );

    // Next-state, datapath and registered-output decisions for the FSM.
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        sum_sh_d  = sum_sh_q;
        cnt_d     = cnt_q;
        cmsb_d    = cmsb_q;
        busy_d    = busy_q;
        done_d    = done_q;
        sum_out_d = sum_out_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        cell_ld   = 1'b0;
        cell_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    a_sh_d  = bus.A_IN;
                    b_sh_d  = (bus.OP == OP_SUB) ? ~bus.B_IN : bus.B_IN;
                    cnt_d   = '0;
                    cell_ld = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                cell_en  = 1'b1;
                sum_sh_d = {cell_s, sum_sh_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // The carry leaving bit WIDTH-2 is the carry into the MSB.
                if (cnt_q == CNT_PREV) begin
                    cmsb_d = cell_co;
                end
                if (cnt_q == CNT_LAST) begin
                    sum_out_d = {cell_s, sum_sh_q[WIDTH-1:1]};
                    cout_d    = cell_co;
                    ovf_d     = cmsb_q ^ cell_co;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_FINISH;
                end
            end

            ST_FINISH: begin
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // All controller state and registered outputs; reset aborts any operation.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: the shift registers are plain flops, so clearing them on reset is cheap and keeps restarts deterministic.
        if (RST) begin
            state_q   <= ST_IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            sum_sh_q  <= '0;
            cnt_q     <= '0;
            cmsb_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_out_q <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            sum_sh_q  <= sum_sh_d;
            cnt_q     <= cnt_d;
            cmsb_q    <= cmsb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sum_out_q <= sum_out_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.SUM_OUT  = sum_out_q;
    assign bus.COUT_OUT = cout_q;
    assign bus.OVF_OUT  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random bench for serial_add_ctrl with a result scoreboard.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   cyc;
    exp_t exp_q[$];
    logic [WIDTH-1:0] held_sum;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Independent reference: (A +/- B) mod 2^WIDTH with carry and signed overflow.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic op);
        exp_t           r;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   t;
        bb     = op ? ~b : b;
        t      = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(op);
        r.sum  = t[WIDTH-1:0];
        r.cout = t[WIDTH];
        r.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Entered on the first negedge after the accepting edge; waits for DONE
    // (bounded), then checks timing and the scoreboard head.
    task automatic wait_and_check(input string tag);
        int   lat;
        int   busy_cnt;
        logic stable;
        exp_t e;
        lat = 1;
        busy_cnt = 0;
        stable = 1'b1;
        while (bus.DONE !== 1'b1 && lat <= 4 * WIDTH) begin
            if (bus.BUSY === 1'b1) busy_cnt++;
            if (bus.SUM_OUT !== held_sum) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_done_seen"}, 32'(bus.DONE), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(WIDTH + 1));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
        chk({tag, "_busy_at_done"}, 32'(bus.BUSY), 32'd0);
        chk({tag, "_sum_stable"}, 32'(stable), 32'd1);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_scoreboard: observed empty queue expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_sum"}, 32'(bus.SUM_OUT), 32'(e.sum));
            chk({tag, "_cout"}, 32'(bus.COUT_OUT), 32'(e.cout));
            chk({tag, "_ovf"}, 32'(bus.OVF_OUT), 32'(e.ovf));
            held_sum = e.sum;
        end
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic op);
        @(negedge clk);
        bus.A_IN  = a;
        bus.B_IN  = b;
        bus.OP    = op;
        bus.START = 1'b1;
        exp_q.push_back(model(a, b, op));
        @(negedge clk);
        bus.START = 1'b0;
        wait_and_check(tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(bus.DONE), 32'd0);
    endtask

    initial begin
        int t1;
        int t2;
        int done_hits;
        n_cmp     = 0;
        n_err     = 0;
        cyc       = 0;
        held_sum  = '0;
        rst       = 1'b1;
        bus.START = 1'b0;
        bus.OP    = 1'b0;
        bus.A_IN  = '0;
        bus.B_IN  = '0;

        // Reset state.
        @(negedge clk);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_done", 32'(bus.DONE), 32'd0);
        chk("rst_sum", 32'(bus.SUM_OUT), 32'd0);
        chk("rst_cout", 32'(bus.COUT_OUT), 32'd0);
        chk("rst_ovf", 32'(bus.OVF_OUT), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed operations.
        run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
        run_op("add_7f_7f", 8'h7F, 8'h7F, 1'b0);
        run_op("sub_10_20", 8'h10, 8'h20, 1'b1);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1);

        // Asynchronous reset during the fourth SHIFT cycle.
        @(negedge clk);
        bus.A_IN  = 8'h5A;
        bus.B_IN  = 8'h3C;
        bus.OP    = 1'b0;
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", 32'(bus.BUSY), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.BUSY), 32'd0);
        chk("abort_done", 32'(bus.DONE), 32'd0);
        chk("abort_sum", 32'(bus.SUM_OUT), 32'd0);
        chk("abort_cout", 32'(bus.COUT_OUT), 32'd0);
        chk("abort_ovf", 32'(bus.OVF_OUT), 32'd0);
        held_sum = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_hits = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.DONE === 1'b1) done_hits++;
        end
        chk("abort_no_done", 32'(done_hits), 32'd0);
        run_op("after_abort", 8'h01, 8'h01, 1'b0);

        // START held high; operands change mid-operation.
        @(negedge clk);
        bus.A_IN  = 8'h12;
        bus.B_IN  = 8'h34;
        bus.OP    = 1'b0;
        bus.START = 1'b1;
        exp_q.push_back(model(8'h12, 8'h34, 1'b0));
        @(negedge clk);
        chk("hold_busy1", 32'(bus.BUSY), 32'd1);
        bus.A_IN = 8'h55;
        bus.B_IN = 8'h11;
        exp_q.push_back(model(8'h55, 8'h11, 1'b0));
        wait_and_check("hold_op1");
        t1 = cyc;
        @(negedge clk);
        chk("hold_pulse1", 32'(bus.DONE), 32'd0);
        @(negedge clk);
        chk("hold_busy2", 32'(bus.BUSY), 32'd1);
        bus.START = 1'b0;
        wait_and_check("hold_op2");
        t2 = cyc;
        chk("hold_period", 32'(t2 - t1), 32'(WIDTH + 2));
        @(negedge clk);
        chk("hold_pulse2", 32'(bus.DONE), 32'd0);

        // Random sweep.
        for (int i = 0; i < 1000; i++) begin
            run_op("rand", WIDTH'($urandom_range(0, 255)), WIDTH'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)));
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
